bias_grad_acc: RTL and testbench
================================

Name: bias_grad_acc

Overview:
- Backward-pass counterpart of the forward bias adder: accumulates per-column bias gradients (dL/db) over a batch of Q8.8 error samples.
- Emits one registered gradient word per completed or flushed batch.
- Sits after the loss/activation-derivative stage, one instance per systolic column. Its output feeds the bias-update path.

Parameters:
- DATA_W, 16, sample and output width (signed Q8.8).
- FRAC_W, 8, fractional bits; informational, no rescaling is done internally.
- BATCH_LOG2, 2, batch size is 2^BATCH_LOG2 samples (1..2^BATCH_LOG2 allowed, 0 means batch of 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- grad_valid_in  input  1  grad_data_in holds a valid sample this cycle.
- grad_data_in  input  DATA_W  signed Q8.8 gradient sample.
- grad_flush_in  input  1  close the current partial batch and emit it.
- grad_data_out  output  DATA_W  signed Q8.8 accumulated (or mean) bias gradient.
- grad_valid_out  output  1  one-cycle strobe; grad_data_out is valid.
- grad_busy_out  output  1  a batch is open (at least one sample accepted, not yet emitted).

Behaviour:
- Accumulator width: ACC_W = DATA_W + BATCH_LOG2, signed. Samples are sign-extended, so the accumulator never overflows within a batch. Sample counter is BATCH_LOG2+1 bits.
- Reset: grad_data_out=0, grad_valid_out=0, grad_busy_out=0, accumulator=0, count=0, state=IDLE.
- States:
  - IDLE (no open batch).
  - ACCUM (batch open).
- Final-sample condition: a valid sample is accepted and count+1 == 2^BATCH_LOG2.
- IDLE transitions:
  - valid_in, not final → acc=sext(data), count=1, go to ACCUM.
  - valid_in, final (batch of 1) → emit, stay in IDLE.
  - flush alone → no-op, no output.
- ACCUM transitions:
  - valid_in, not final → acc+=sext(data), count++.
  - valid_in, final → emit, go to IDLE.
  - flush without valid → emit the current acc, go to IDLE.
  - flush with valid in the same cycle → the sample is included, then emit, go to IDLE.
- Emit: on the same edge that accepts the final sample (or the flush), the block registers:
  - grad_data_out = sat(acc_next);
  - grad_valid_out = 1;
  - accumulator and count clear to 0.
- Latency: last sample or flush at cycle t → grad_valid_out high during cycle t+1, for exactly one cycle.
- Back-to-back operation: a valid sample in cycle t+1 opens a new batch with no bubble.
- grad_data_out is 0 whenever grad_valid_out is 0.
- Saturation:
  - Clamp ACC_W to DATA_W: above 32767 gives 0x7FFF, below −32768 gives 0x8000.
  - No rounding; the Q-format is unchanged.
- grad_busy_out = (state == ACCUM), registered.
- Reset mid-batch discards the partial sum; no output is produced.

Optional Feature:
- Macro: BIAS_GRAD_MEAN_EN.
- When defined: before saturation, acc_next is arithmetic-shifted right by BATCH_LOG2 (floor, toward −inf), giving the batch mean.
  - Flushed partial batches are still divided by 2^BATCH_LOG2, so the scale stays constant for the optimizer.
  - Saturation therefore never triggers on a full batch.
- When undefined: the raw sum is emitted, saturated.

Decomposition:
- Shared package fxp_pkg holds:
  - DATA_W / FRAC_W constants;
  - the Q8.8 sample typedef (signed logic [15:0]);
  - the state enum {IDLE, ACCUM}.
- One natural sub-module, fxp_sat: a parameterised signed width reducer with clamp, reusable by other accumulating blocks.

Test Plan:
- Full batch, BATCH_LOG2=2, samples 0x0100, 0x0200, 0xFF00, 0x0080 → one-cycle valid after the 4th sample.
  - Data 0x0280.
  - 0x00A0 with BIAS_GRAD_MEAN_EN.
- Saturation: 4×0x7000 → 0x7FFF; 4×0x9000 → 0x8000.
  - Mean variant: 0x7000 and 0x9000 respectively.
- Flush: 0x0100, 0x0100, then flush alone → 0x0200 (mean: 0x0080).
  - Flush with a sample in the same cycle includes that sample.
  - Flush while IDLE produces no strobe.
- Back-to-back: 8 consecutive valid samples of 0x0100 → strobes one cycle after samples 4 and 8, each 0x0400.
  - busy never drops between the two batches except in the emit cycle.
- Reset mid-batch: 2 samples, then rst, then 4×0x0010 → single output 0x0040, with no contribution from the pre-reset samples.
- Valid gaps: samples interleaved with idle cycles → the same sum as the contiguous case; grad_data_out stays 0 when not valid.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the Q8.8 training datapath: widths,
// the sample type and the accumulator state encoding.
package fxp_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [DATA_W-1:0] q8_8_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/bias_grad_acc_if.sv
// Sample/result bundle between the activation-derivative stage and the
// bias-gradient accumulator; the master drives samples, the slave returns results.
interface bias_grad_acc_if #(
  parameter int DATA_W = 16
);

  logic                     grad_valid_in;
  logic signed [DATA_W-1:0] grad_data_in;
  logic                     grad_flush_in;
  logic signed [DATA_W-1:0] grad_data_out;
  logic                     grad_valid_out;
  logic                     grad_busy_out;

  modport master (
    output grad_valid_in, grad_data_in, grad_flush_in,
    input  grad_data_out, grad_valid_out, grad_busy_out
  );

  modport slave (
    input  grad_valid_in, grad_data_in, grad_flush_in,
    output grad_data_out, grad_valid_out, grad_busy_out
  );

endinterface

// File: rtl/fxp_sat.sv
// Signed width reducer: clamps an IN_W-bit value to the OUT_W-bit range,
// returning the most positive or most negative code on overflow.
module fxp_sat #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // Value fits when every bit above the target sign bit equals that sign bit.
  logic [IN_W-OUT_W:0] upper;
  logic                fits;

  assign upper = din[IN_W-1:OUT_W-1];
  assign fits  = (&upper) || ~(|upper);

  always_comb begin
    if (fits) begin
      dout = din[OUT_W-1:0];
    end else if (din[IN_W-1]) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/bias_grad_acc.sv
// Per-column bias-gradient accumulator: sums a batch of Q8.8 error samples and
// emits one saturated word per full or flushed batch. Define BIAS_GRAD_MEAN_EN
// to emit the batch mean (sum >>> BATCH_LOG2) instead of the raw sum.
module bias_grad_acc
  import fxp_pkg::state_e, fxp_pkg::IDLE, fxp_pkg::ACCUM;
#(
  parameter int DATA_W     = fxp_pkg::DATA_W,
  parameter int FRAC_W     = fxp_pkg::FRAC_W,
  parameter int BATCH_LOG2 = 2
) (
  input logic              clk,
  input logic              rst,
  bias_grad_acc_if.slave   bus
);

  localparam int ACC_W = DATA_W + BATCH_LOG2;
  localparam int CNT_W = BATCH_LOG2 + 1;
  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(1 << BATCH_LOG2);

  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
    $error("bias_grad_acc: FRAC_W must lie in [0, DATA_W)");
  end

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] data_out_q, data_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     busy_q, busy_d;

  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  sat_in;
  logic signed [DATA_W-1:0] sat_out;
  logic                     final_sample;
  logic                     emit;

  fxp_sat #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat (
    .din  (sat_in),
    .dout (sat_out)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // holding its old value, which would infer a latch.
  always_comb begin
    sample_ext   = ACC_W'(bus.grad_data_in);
    acc_sum      = acc_q + (bus.grad_valid_in ? sample_ext : '0);
    final_sample = bus.grad_valid_in && ((cnt_q + CNT_W'(1)) == BATCH_CNT);
    // A flush in IDLE only closes a batch if it carries a sample to close.
    emit         = final_sample ||
                   (bus.grad_flush_in && (state_q == ACCUM || bus.grad_valid_in));

`ifdef BIAS_GRAD_MEAN_EN
    // Partial batches still divide by the full batch size to keep scale fixed.
    sat_in = acc_sum >>> BATCH_LOG2;
`else
    sat_in = acc_sum;
`endif

    state_d     = state_q;
    acc_d       = acc_sum;
    cnt_d       = bus.grad_valid_in ? cnt_q + CNT_W'(1) : cnt_q;
    data_out_d  = '0;
    valid_out_d = 1'b0;

    if (emit) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      data_out_d  = sat_out;
      valid_out_d = 1'b1;
    end else if (bus.grad_valid_in) begin
      state_d = ACCUM;
    end

    busy_d = (state_d == ACCUM);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.grad_data_out  = data_out_q;
  assign bus.grad_valid_out = valid_out_q;
  assign bus.grad_busy_out  = busy_q;

endmodule

// File: tb/tb_bias_grad_acc.sv
// Directed bench for bias_grad_acc (BATCH_LOG2=2); expected values follow
// BIAS_GRAD_MEAN_EN so the same bench covers both builds.
module tb_bias_grad_acc;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bias_grad_acc_if #(.DATA_W(16)) bus ();

  bias_grad_acc #(
    .DATA_W     (16),
    .FRAC_W     (8),
    .BATCH_LOG2 (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BIAS_GRAD_MEAN_EN
  localparam logic [15:0] EXP_MIX   = 16'h00A0;
  localparam logic [15:0] EXP_POS   = 16'h7000;
  localparam logic [15:0] EXP_NEG   = 16'h9000;
  localparam logic [15:0] EXP_FL2   = 16'h0080;
  localparam logic [15:0] EXP_FLV   = 16'h0100;
  localparam logic [15:0] EXP_B2B   = 16'h0100;
  localparam logic [15:0] EXP_RST   = 16'h0010;
`else
  localparam logic [15:0] EXP_MIX   = 16'h0280;
  localparam logic [15:0] EXP_POS   = 16'h7FFF;
  localparam logic [15:0] EXP_NEG   = 16'h8000;
  localparam logic [15:0] EXP_FL2   = 16'h0200;
  localparam logic [15:0] EXP_FLV   = 16'h0400;
  localparam logic [15:0] EXP_B2B   = 16'h0400;
  localparam logic [15:0] EXP_RST   = 16'h0040;
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are then read 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic f);
    bus.grad_valid_in = v;
    bus.grad_data_in  = d;
    bus.grad_flush_in = f;
    @(posedge clk);
    #1;
    bus.grad_valid_in = 1'b0;
    bus.grad_data_in  = 16'h0000;
    bus.grad_flush_in = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [15:0] d,
                            input logic b);
    check({tag, ".valid"}, {15'b0, bus.grad_valid_out}, {15'b0, v});
    check({tag, ".data"},  bus.grad_data_out, d);
    check({tag, ".busy"},  {15'b0, bus.grad_busy_out}, {15'b0, b});
  endtask

  task automatic batch4(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] e,
                        input logic [15:0] exp);
    step(1'b1, a, 1'b0);
    expect_out({tag, ".s1"}, 1'b0, 16'h0000, 1'b1);
    step(1'b1, b, 1'b0);
    step(1'b1, c, 1'b0);
    expect_out({tag, ".s3"}, 1'b0, 16'h0000, 1'b1);
    step(1'b1, e, 1'b0);
    expect_out({tag, ".emit"}, 1'b1, exp, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out({tag, ".after"}, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.grad_valid_in = 1'b0;
    bus.grad_data_in  = 16'h0000;
    bus.grad_flush_in = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    batch4("mix", 16'h0100, 16'h0200, 16'hFF00, 16'h0080, EXP_MIX);
    batch4("satpos", 16'h7000, 16'h7000, 16'h7000, 16'h7000, EXP_POS);
    batch4("satneg", 16'h9000, 16'h9000, 16'h9000, 16'h9000, EXP_NEG);

    // Flush alone closes a two-sample batch.
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    expect_out("flush.open", 1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    expect_out("flush.emit", 1'b1, EXP_FL2, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out("flush.after", 1'b0, 16'h0000, 1'b0);

    // Flush together with a sample includes that sample.
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h0300, 1'b1);
    expect_out("flushv.emit", 1'b1, EXP_FLV, 1'b0);

    // Flush while idle must do nothing.
    step(1'b0, 16'h0000, 1'b1);
    expect_out("flush.idle", 1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out("flush.idle2", 1'b0, 16'h0000, 1'b0);

    // Eight back-to-back samples: two batches, no bubble.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'h0100, 1'b0);
      if (i == 4 || i == 8) begin
        expect_out($sformatf("b2b.s%0d", i), 1'b1, EXP_B2B, 1'b0);
      end else begin
        expect_out($sformatf("b2b.s%0d", i), 1'b0, 16'h0000, 1'b1);
      end
    end
    step(1'b0, 16'h0000, 1'b0);
    expect_out("b2b.after", 1'b0, 16'h0000, 1'b0);

    // Reset mid-batch discards the partial sum.
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("midrst", 1'b0, 16'h0000, 1'b0);
    batch4("postrst", 16'h0010, 16'h0010, 16'h0010, 16'h0010, EXP_RST);

    // Samples separated by idle cycles give the contiguous result.
    step(1'b1, 16'h0100, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out("gap.1", 1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h0200, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out("gap.2", 1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out("gap.3", 1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h0080, 1'b0);
    expect_out("gap.emit", 1'b1, EXP_MIX, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    expect_out("gap.after", 1'b0, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
